// File: rtl/five_b_down_counter_if.sv
// ----------------------------------------------------------------------------
// five_b_down_counter_if
//   Control/status bundle for the loadable down-counter.
//
//   Signals
//     ce        count enable; decrement only while RUN
//     ld        load strobe; samples din and enters RUN
//     din       load value (saturated to MAX inside the counter)
//     count     current count
//     tc        one-cycle terminal-count pulse
//     busy      high while in RUN
//     done      high while in DONE (sticky until ld or mr)
//     state_dbg raw FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
//
//   Handshake: there is no valid/ready pair. ld and ce are level strobes
//   sampled on every falling clk edge. ld is taken unconditionally and wins
//   over ce on the same edge. The counter is always ready, and its outputs
//   are valid every cycle.
//
//   Modports
//     master  drives ce/ld/din and observes status (testbench or parent)
//     slave   the counter itself
// ----------------------------------------------------------------------------
interface five_b_down_counter_if #(
    parameter int WIDTH = 5
);
    logic             ce;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output ce, ld, din,
        input  count, tc, busy, done, state_dbg
    );

    modport slave (
        input  ce, ld, din,
        output count, tc, busy, done, state_dbg
    );
endinterface

// File: rtl/five_b_down_counter.sv
// ----------------------------------------------------------------------------
// five_b_down_counter
//   Loadable down-counter with run/done sequencing. It counts a loaded index
//   back to 0 and pulses tc on the ce edge after zero is reached. It then
//   either parks in DONE (AUTO_RL=0) or reloads MAX and keeps running
//   (AUTO_RL=1). Load values above MAX saturate to MAX.
//
//   All registers update on the FALLING edge of clk.
//
//   Ports
//     clk  in     clock (falling-edge active)
//     mr   in     master reset, asynchronous, active-high
//     bus  slave  ce, ld, din in; count, tc, busy, done, state_dbg out
//
//   Parameters
//     WIDTH    counter width in bits
//     MAX      highest legal count
//     AUTO_RL  0: stop in DONE at zero; 1: reload MAX at zero and keep running
// ----------------------------------------------------------------------------
module five_b_down_counter #(
    parameter int WIDTH   = 5,
    parameter int MAX     = 17,
    parameter int AUTO_RL = 0
) (
    input  logic                  clk,
    input  logic                  mr,
    five_b_down_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    // Next-state / next-count. tc defaults low, so any pulse lasts exactly one
    // cycle. A load overrides everything, including the tc-generating edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (bus.ld) begin
            state_d = RUN;
            count_d = (bus.din > MAX_V) ? MAX_V : bus.din;
        end else if (state_q == RUN && bus.ce) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                // The zero count has been held for one ce edge: fire tc.
                tc_d = 1'b1;
                if (AUTO_RL != 0) begin
                    count_d = MAX_V;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(negedge clk or posedge mr) begin
        if (mr) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // busy/done decode straight from the state register, so they change on
    // the same edge as the state itself.
    assign bus.count     = count_q;
    assign bus.tc        = tc_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.state_dbg = state_q;

endmodule
